// File: rtl/mac_stream_dot.sv
// mac_stream_dot: streaming signed dot-product engine.
// Operand pairs arrive over a valid/ready handshake and pass through a
// two-stage multiply/accumulate pipeline. One rounded, saturated result is
// returned per vector over a second valid/ready handshake.
module mac_stream_dot #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int OUT_W   = 8,
    parameter int MAX_LEN = 256,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int SH_W    = $clog2(ACC_W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         vec_len,
    input  logic [SH_W-1:0]          shift,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic signed [ACC_W-1:0]  out_acc,
    output logic                     out_sat,
    output logic                     busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [LEN_W-1:0]     MAX_LEN_L  = LEN_W'(MAX_LEN);
    localparam logic signed [ACC_W:0] ROUND_ONE = (ACC_W + 1)'(1);
    localparam logic signed [ACC_W:0] SAT_MAX   = (ACC_W + 1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN   = (ACC_W + 1)'(-(2 ** (OUT_W - 1)));

    // Control state
    logic [1:0]       r_state;
    logic [LEN_W-1:0] r_len;
    logic [SH_W-1:0]  r_shift;
    logic [LEN_W-1:0] r_cnt;

    // Pipeline state
    logic signed [2*DATA_W-1:0] r_prod;
    logic                       r_prod_vld;
    logic signed [ACC_W-1:0]    r_acc;

    // Result registers
    logic signed [OUT_W-1:0] r_out_data;
    logic signed [ACC_W-1:0] r_out_acc;
    logic                    r_out_sat;

    // Combinational nets
    logic                       w_start_ok;
    logic                       w_beat;
    logic                       w_last_beat;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_final;
    logic signed [ACC_W:0]      w_half;
    logic signed [ACC_W:0]      w_round_sum;
    logic signed [ACC_W:0]      w_round;
    logic signed [OUT_W-1:0]    w_sat_data;
    logic                       w_sat;

    // A start is honoured only from IDLE and only for a legal length.
    assign w_start_ok  = (r_state == S_IDLE) && start &&
                         (vec_len != '0) && (vec_len <= MAX_LEN_L);
    assign in_ready    = (r_state == S_ACCUM) && (r_cnt < r_len);
    assign w_beat      = in_valid && in_ready;
    assign w_last_beat = (r_cnt + LEN_W'(1)) == r_len;

    // Both operands are signed, so they are sign-extended to the product width.
    assign w_prod     = in_a * in_b;
    assign w_prod_ext = ACC_W'(r_prod);
    // Accumulator plus whatever product is still in flight in stage 1.
    assign w_final    = r_acc + (r_prod_vld ? w_prod_ext : '0);

    assign out_valid = (r_state == S_RESULT);
    assign busy      = (r_state != S_IDLE);
    assign out_data  = r_out_data;
    assign out_acc   = r_out_acc;
    assign out_sat   = r_out_sat;

    // Round-half-up with an arithmetic shift, then clip to the output range.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_half = '0;
        if (r_shift != '0) begin
            w_half = ROUND_ONE << (r_shift - SH_W'(1));
        end
        // One extra bit of headroom keeps the rounding add from overflowing.
        w_round_sum = (ACC_W + 1)'(w_final) + w_half;
        w_round     = w_round_sum >>> r_shift;

        w_sat      = 1'b0;
        w_sat_data = w_round[OUT_W-1:0];
        if (w_round > SAT_MAX) begin
            w_sat      = 1'b1;
            w_sat_data = SAT_MAX[OUT_W-1:0];
        end else if (w_round < SAT_MIN) begin
            w_sat      = 1'b1;
            w_sat_data = SAT_MIN[OUT_W-1:0];
        end
    end

    // Vector sequencing: IDLE -> ACCUM -> DRAIN -> RESULT -> IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_len   <= vec_len;
                        r_shift <= shift;
                        r_cnt   <= '0;
                        r_state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last_beat) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_RESULT;
                end
                S_RESULT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage 1 registers each accepted product; stage 2 folds it into the accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod     <= '0;
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else if (w_start_ok) begin
            r_prod_vld <= 1'b0;
            r_acc      <= '0;
        end else begin
            if (w_beat) begin
                r_prod <= w_prod;
            end
            r_prod_vld <= w_beat;
            if (r_prod_vld) begin
                r_acc <= w_final;
            end
        end
    end

    // Capture the final sum and its rounded, saturated form during DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data <= '0;
            r_out_acc  <= '0;
            r_out_sat  <= 1'b0;
        end else if (r_state == S_DRAIN) begin
            r_out_data <= w_sat_data;
            r_out_acc  <= w_final;
            r_out_sat  <= w_sat;
        end
    end

endmodule

// File: tb/tb_mac_stream_dot.sv
// Testbench for mac_stream_dot: directed vectors, expected results queued on
// start and compared by an independent monitor on each output handshake.
module tb_mac_stream_dot;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 24;
    localparam int OUT_W  = 8;
    localparam int LEN_W  = 9;
    localparam int SH_W   = 5;

    typedef struct {
        longint data;
        longint acc;
        longint sat;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic [LEN_W-1:0]         vec_len = '0;
    logic [SH_W-1:0]          shift = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_a = '0;
    logic signed [DATA_W-1:0] in_b = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic signed [OUT_W-1:0]  out_data;
    logic signed [ACC_W-1:0]  out_acc;
    logic                     out_sat;
    logic                     busy;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    mac_stream_dot #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .OUT_W  (OUT_W),
        .MAX_LEN(256)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .vec_len  (vec_len),
        .shift    (shift),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_acc  (out_acc),
        .out_sat  (out_sat),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input longint data, input longint acc, input longint sat);
        exp_t e;
        e.data = data;
        e.acc  = acc;
        e.sat  = sat;
        exp_q.push_back(e);
    endtask

    task automatic start_vec(input int len, input int sh);
        start   = 1'b1;
        vec_len = LEN_W'(len);
        shift   = SH_W'(sh);
        tick();
        start = 1'b0;
    endtask

    // Present one operand pair and hold it until the engine accepts it.
    task automatic send(input int a, input int b);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
        for (int i = 0; i < 20 && !done; i++) begin
            done = in_ready;
            tick();
        end
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) tick();
        check("wait_idle", busy, 0);
    endtask

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", longint'(out_data), e.data);
                check("out_acc", longint'(out_acc), e.acc);
                check("out_sat", longint'(out_sat), e.sat);
            end
        end
    end

    initial begin
        int beats;
        bit vpat[7] = '{1, 0, 0, 1, 0, 1, 1};
        int pa[7]   = '{2, 0, 0, -3, 0, 4, 100};
        int pb[7]   = '{5, 0, 0, 6, 0, -7, 100};

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_acc", longint'(out_acc), 0);
        check("rst_out_sat", out_sat, 0);
        reset = 1'b0;
        tick();

        // Basic dot product with latency check
        push_exp(70, 70, 0);
        start_vec(4, 0);
        send(1, 5);
        send(2, 6);
        send(3, 7);
        send(4, 8);
        in_valid = 1'b0;
        check("lat_drain_valid", out_valid, 0);
        check("lat_drain_ready", in_ready, 0);
        tick();
        check("lat_result_valid", out_valid, 1);
        wait_idle();

        // Saturation, then rounding without saturation
        push_exp(127, 64516, 1);
        start_vec(4, 0);
        for (int i = 0; i < 4; i++) send(127, 127);
        in_valid = 1'b0;
        wait_idle();

        push_exp(126, 64516, 0);
        start_vec(4, 9);
        for (int i = 0; i < 4; i++) send(127, 127);
        in_valid = 1'b0;
        wait_idle();

        // Negative products with rounding
        push_exp(-127, -32512, 0);
        start_vec(2, 8);
        send(-128, 127);
        send(-128, 127);
        in_valid = 1'b0;
        wait_idle();

        // Input gaps, a trailing in_valid in DRAIN, then output backpressure
        out_ready = 1'b0;
        push_exp(-36, -36, 0);
        start_vec(3, 0);
        beats = 0;
        for (int i = 0; i < 7; i++) begin
            in_valid = vpat[i];
            in_a     = DATA_W'(pa[i]);
            in_b     = DATA_W'(pb[i]);
            if (in_valid && in_ready) beats++;
            tick();
        end
        in_valid = 1'b0;
        check("stall_beats", beats, 3);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", longint'(out_data), -36);
            check("stall_in_ready", in_ready, 0);
            check("stall_busy", busy, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("release_busy", busy, 0);
        check("release_out_valid", out_valid, 0);

        // Reset in the middle of a vector
        start_vec(4, 0);
        send(50, 50);
        send(50, 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_out_acc", longint'(out_acc), 0);
        check("abort_out_data", longint'(out_data), 0);
        for (int i = 0; i < 4; i++) begin
            check("abort_out_valid", out_valid, 0);
            tick();
        end
        push_exp(2, 2, 0);
        start_vec(2, 0);
        send(1, 1);
        send(1, 1);
        wait_idle();

        // Illegal lengths are ignored
        start_vec(0, 0);
        check("len0_busy", busy, 0);
        start_vec(257, 0);
        check("len257_busy", busy, 0);

        // A start during ACCUM does not change the running length
        push_exp(6, 6, 0);
        start_vec(3, 0);
        send(1, 1);
        start   = 1'b1;
        vec_len = LEN_W'(1);
        send(2, 1);
        start = 1'b0;
        check("overlap_busy", busy, 1);
        send(3, 1);
        in_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("results_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

endmodule
